// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl -- vending-machine transaction controller
//
// Accepts debounced single-cycle coin/cancel pulses, accumulates credit in
// half-yuan units, decides dispense/refund and presents a 2-bit status code
// to the LED indicator block. The state register *is* the status code, so
// number_zhuangtai has no decode logic behind it. All hold timing lives here.
//
// Optional feature macro: VEND_TIMEOUT_EN
//   defined   -> COLLECT auto-refunds after TIMEOUT_TICKS ticks with no
//                accepted coin (tick counter restarts on every accepted coin)
//   undefined -> COLLECT waits indefinitely for price or cancel
//
// Parameters:
//   PRICE          item price, half-yuan units (1..31)
//   TICK_DIV       clk cycles per 0.2 s tick
//   HOLD_TICKS     ticks each DISPENSE / CHANGE status is held
//   TIMEOUT_TICKS  idle ticks in COLLECT before auto-refund
//
// Ports:
//   clk               in   system clock (50 MHz)
//   rst_n             in   asynchronous active-low reset
//   coin_half         in   pulse, 0.5 yuan inserted
//   coin_one          in   pulse, 1 yuan inserted
//   cancel            in   pulse, user cancel
//   number_zhuangtai  out  status: 00 IDLE, 10 COLLECT, 11 DISPENSE, 01 CHANGE
//   credit            out  current credit, half-yuan units
//   change            out  change/refund amount for the current CHANGE phase
//   dispense          out  pulse, release item (first cycle of DISPENSE)
//   coin_reject       out  pulse, coin(s) of this cycle were ignored
// ---------------------------------------------------------------------------
module vend_ctrl #(
    parameter int PRICE         = 5,
    parameter int TICK_DIV      = 10_000_000,
    parameter int HOLD_TICKS    = 10,
    parameter int TIMEOUT_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_half,
    input  logic       coin_one,
    input  logic       cancel,
    output logic [1:0] number_zhuangtai,
    output logic [4:0] credit,
    output logic [4:0] change,
    output logic       dispense,
    output logic       coin_reject
);

    // Encodings equal the status codes consumed by the LED block.
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_COLLECT  = 2'b10,
        S_DISPENSE = 2'b11,
        S_CHANGE   = 2'b01
    } state_t;

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HMAX = (HOLD_TICKS > TIMEOUT_TICKS) ? HOLD_TICKS : TIMEOUT_TICKS;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [5:0]    PRICE6    = 6'(PRICE);
    localparam logic [4:0]    PRICE5    = 5'(PRICE);
`ifdef VEND_TIMEOUT_EN
    localparam logic [HW-1:0] TOUT_LAST = HW'(TIMEOUT_TICKS - 1);
`endif

    state_t          state_reg;
    logic [4:0]      credit_reg;
    logic [4:0]      change_reg;
    logic            dispense_reg;
    logic            coin_reject_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [HW-1:0]   hold_cnt_reg;

    // Combinational helpers (all derived from registered state + inputs)
    logic [1:0]      coin_val;
    logic            coin_any;
    logic [5:0]      sum6;
    logic            sum_ovf;
    logic            coin_ok;
    logic            reach;
    logic [4:0]      over5;
    logic            tick;
    logic            hold_done;

    always_comb begin
        // coin_one weighs 2, coin_half weighs 1: together they form the value.
        coin_val  = {coin_one, coin_half};
        coin_any  = coin_one | coin_half;
        // Six bits wide so a sum above 31 is seen rather than wrapped.
        sum6      = {1'b0, credit_reg} + {4'b0000, coin_val};
        sum_ovf   = sum6[5];
        coin_ok   = coin_any & ~sum_ovf;
        reach     = (sum6 >= PRICE6);
        // Only used when sum6 <= 31, so 5-bit arithmetic is exact.
        over5     = sum6[4:0] - PRICE5;
        tick      = (tick_cnt_reg == TICK_LAST);
        hold_done = tick && (hold_cnt_reg == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            credit_reg      <= '0;
            change_reg      <= '0;
            dispense_reg    <= 1'b0;
            coin_reject_reg <= 1'b0;
            tick_cnt_reg    <= '0;
            hold_cnt_reg    <= '0;
        end else begin
            // Pulses default low; free-running tick divider. Every state
            // change below overrides both counters back to zero.
            dispense_reg    <= 1'b0;
            coin_reject_reg <= 1'b0;
            tick_cnt_reg    <= tick ? '0 : tick_cnt_reg + TW'(1);

            case (state_reg)
                S_IDLE: begin
                    if (coin_any) begin
                        tick_cnt_reg <= '0;
                        hold_cnt_reg <= '0;
                        if (reach) begin
                            // Only reachable when PRICE <= 3.
                            state_reg    <= S_DISPENSE;
                            credit_reg   <= '0;
                            change_reg   <= {3'b000, coin_val} - PRICE5;
                            dispense_reg <= 1'b1;
                        end else begin
                            state_reg  <= S_COLLECT;
                            credit_reg <= {3'b000, coin_val};
                        end
                    end
                end

                S_COLLECT: begin
                    // Coins are refused when cancel wins the cycle or when
                    // they would push credit past 31.
                    coin_reject_reg <= coin_any & (cancel | sum_ovf);
                    if (cancel) begin
                        state_reg    <= S_CHANGE;
                        change_reg   <= credit_reg;
                        credit_reg   <= '0;
                        tick_cnt_reg <= '0;
                        hold_cnt_reg <= '0;
                    end else if (coin_ok && reach) begin
                        state_reg    <= S_DISPENSE;
                        change_reg   <= over5;
                        credit_reg   <= '0;
                        dispense_reg <= 1'b1;
                        tick_cnt_reg <= '0;
                        hold_cnt_reg <= '0;
                    end else if (coin_ok) begin
                        credit_reg <= sum6[4:0];
`ifdef VEND_TIMEOUT_EN
                        // An accepted coin restarts the inactivity timer.
                        tick_cnt_reg <= '0;
                        hold_cnt_reg <= '0;
`endif
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (tick) begin
                        if (hold_cnt_reg == TOUT_LAST) begin
                            // Auto-refund: shown as CHANGE (blink).
                            state_reg    <= S_CHANGE;
                            change_reg   <= credit_reg;
                            credit_reg   <= '0;
                            hold_cnt_reg <= '0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + HW'(1);
                        end
                    end
`endif
                end

                S_DISPENSE: begin
                    coin_reject_reg <= coin_any;
                    if (hold_done) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= (change_reg != 5'd0) ? S_CHANGE : S_IDLE;
                    end else if (tick) begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end

                S_CHANGE: begin
                    coin_reject_reg <= coin_any;
                    if (hold_done) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= S_IDLE;
                        change_reg   <= '0;
                    end else if (tick) begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign number_zhuangtai = state_reg;
    assign credit           = credit_reg;
    assign change           = change_reg;
    assign dispense         = dispense_reg;
    assign coin_reject      = coin_reject_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl -- scoreboard bench for vend_ctrl
//
// A transaction-level reference model (credit, phase, deadline cycle numbers)
// predicts every observable event: a pulse on dispense/coin_reject or any
// change of status/credit/change. Predicted events are queued with the edge
// number on which they must appear; an independent monitor pops and compares
// whenever the DUT shows an event. Build with +define+VEND_TIMEOUT_EN to
// exercise the auto-refund path.
// ---------------------------------------------------------------------------
module tb_vend_ctrl;

    localparam int PRICE = 5;
    localparam int DIV   = 4;
    localparam int HOLD  = 2;
    localparam int TOUT  = 3;

    localparam int ST_IDLE = 0;
    localparam int ST_COLL = 2;
    localparam int ST_DISP = 3;
    localparam int ST_CHG  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_half = 1'b0;
    logic       coin_one = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] number_zhuangtai;
    logic [4:0] credit;
    logic [4:0] change;
    logic       dispense;
    logic       coin_reject;

    vend_ctrl #(
        .PRICE(PRICE), .TICK_DIV(DIV), .HOLD_TICKS(HOLD), .TIMEOUT_TICKS(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_half(coin_half), .coin_one(coin_one), .cancel(cancel),
        .number_zhuangtai(number_zhuangtai), .credit(credit), .change(change),
        .dispense(dispense), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [4:0] cr;
        logic [4:0] ch;
        logic       d;
        logic       r;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // ---------------- reference model ----------------
    int m_st = ST_IDLE;
    int m_credit = 0;
    int m_change = 0;
    int m_deadline = 0;     // edge at which the current hold phase ends
    int m_to_deadline = 0;  // edge at which COLLECT would time out

    task automatic model_reset();
        m_st = ST_IDLE; m_credit = 0; m_change = 0;
        m_deadline = 0; m_to_deadline = 0;
    endtask

    // Applies the inputs sampled at edge e and queues any visible event.
    task automatic model_step(input int e, input bit h, input bit o, input bit c);
        int v, st0, cr0, ch0;
        bit d, r, to_hit;
        ev_t x;
        v = int'(h) + 2 * int'(o);
        st0 = m_st; cr0 = m_credit; ch0 = m_change;
        d = 1'b0; r = 1'b0; to_hit = 1'b0;
`ifdef VEND_TIMEOUT_EN
        to_hit = (e == m_to_deadline);
`endif
        case (m_st)
            ST_IDLE: if (v > 0) begin
                if (v >= PRICE) begin
                    m_st = ST_DISP; m_change = v - PRICE; m_credit = 0;
                    d = 1'b1; m_deadline = e + HOLD * DIV;
                end else begin
                    m_st = ST_COLL; m_credit = v; m_to_deadline = e + TOUT * DIV;
                end
            end
            ST_COLL: begin
                if (c) begin
                    r = (v > 0);
                    m_st = ST_CHG; m_change = m_credit; m_credit = 0;
                    m_deadline = e + HOLD * DIV;
                end else if (v > 0 && m_credit + v <= 31 && m_credit + v >= PRICE) begin
                    m_st = ST_DISP; m_change = m_credit + v - PRICE; m_credit = 0;
                    d = 1'b1; m_deadline = e + HOLD * DIV;
                end else if (v > 0 && m_credit + v <= 31) begin
                    m_credit = m_credit + v;
                    m_to_deadline = e + TOUT * DIV;
                end else begin
                    r = (v > 0);
                    if (to_hit) begin
                        m_st = ST_CHG; m_change = m_credit; m_credit = 0;
                        m_deadline = e + HOLD * DIV;
                    end
                end
            end
            default: begin
                r = (v > 0);
                if (e == m_deadline) begin
                    if (m_st == ST_DISP && m_change != 0) begin
                        m_st = ST_CHG; m_deadline = e + HOLD * DIV;
                    end else begin
                        m_st = ST_IDLE; m_change = 0;
                    end
                end
            end
        endcase
        if (d || r || m_st != st0 || m_credit != cr0 || m_change != ch0) begin
            x.cyc = e; x.st = 2'(m_st); x.cr = 5'(m_credit); x.ch = 5'(m_change);
            x.d = d; x.r = r;
            exp_q.push_back(x);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input bit h, input bit o, input bit c);
        @(negedge clk);
        coin_half = h; coin_one = o; cancel = c;
        model_step(edge_cnt + 1, h, o, c);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name, input logic [4:0] act);
        checks++;
        if (act !== 5'd0) begin
            errors++;
            $display("FAIL %s: got %0d, expected 0", name, act);
        end else begin
            $display("reset %s = 0 ok", name);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_zero({tag, "_status"}, {3'b000, number_zhuangtai});
        check_zero({tag, "_credit"}, credit);
        check_zero({tag, "_change"}, change);
        check_zero({tag, "_dispense"}, {4'b0000, dispense});
        check_zero({tag, "_coin_reject"}, {4'b0000, coin_reject});
    endtask

    // Asserted between edges so the asynchronous clear is observed on its own.
    task automatic mid_reset();
        @(negedge clk);
        coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_all_zero("async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] prev_st = '0;
    logic [4:0] prev_cr = '0;
    logic [4:0] prev_ch = '0;

    initial begin
        ev_t x;
        int  e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                e = edge_cnt;
                if (dispense || coin_reject || number_zhuangtai != prev_st ||
                    credit != prev_cr || change != prev_ch) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d: got st=%b cr=%0d ch=%0d d=%b r=%b, expected none",
                                 e, number_zhuangtai, credit, change, dispense, coin_reject);
                    end else begin
                        x = exp_q.pop_front();
                        if (x.cyc != e || x.st !== number_zhuangtai || x.cr !== credit ||
                            x.ch !== change || x.d !== dispense || x.r !== coin_reject) begin
                            errors++;
                            $display("FAIL event: got cyc=%0d st=%b cr=%0d ch=%0d d=%b r=%b, expected cyc=%0d st=%b cr=%0d ch=%0d d=%b r=%b",
                                     e, number_zhuangtai, credit, change, dispense, coin_reject,
                                     x.cyc, x.st, x.cr, x.ch, x.d, x.r);
                        end else begin
                            $display("event cyc=%0d st=%b credit=%0d change=%0d dispense=%b reject=%b ok",
                                     e, x.st, x.cr, x.ch, x.d, x.r);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= e) begin
                    x = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_event at cyc=%0d: got no event, expected st=%b cr=%0d ch=%0d d=%b r=%b at cyc=%0d",
                             e, x.st, x.cr, x.ch, x.d, x.r, x.cyc);
                end
            end
            prev_st = number_zhuangtai;
            prev_cr = credit;
            prev_ch = change;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        check_all_zero("por");
        #3 rst_n = 1'b1;

        // 1 + 1 + 0.5 yuan -> exact price, no change
        drive(0, 1, 0); drive(0, 1, 0); drive(1, 0, 0);
        idle(12);
        // 3 yuan -> dispense with change 1, then CHANGE phase
        drive(0, 1, 0); drive(0, 1, 0); drive(0, 1, 0);
        idle(20);
        // cancel beats a simultaneous coin -> refund 2, coin rejected
        drive(0, 1, 0); drive(0, 1, 1);
        idle(12);
        // both coins same cycle -> credit 3; coin during DISPENSE is rejected
        drive(1, 1, 0); drive(0, 1, 0); drive(1, 0, 0);
        idle(10);
        // single coin then long idle (auto-refund only with the timeout build)
        drive(0, 1, 0);
        idle(14);
        drive(0, 0, 1);
        idle(12);
        // reset in the middle of DISPENSE
        drive(0, 1, 0); drive(0, 1, 0); drive(0, 1, 0);
        idle(2);
        mid_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int rn;
            bit h, o, c;
            rn = int'($urandom_range(0, 99));
            h = (rn < 15) || (rn >= 95);
            o = (rn >= 15 && rn < 30) || (rn >= 95);
            c = (rn >= 30 && rn < 36) || (rn == 99);
            drive(h, o, c);
        end
        idle(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unobserved events, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
